// File: rtl/mem_stream_reader.sv
// Streams a contiguous range of a one-cycle-latency memory out as a valid/ready
// stream with a last marker, using a 2-entry return buffer and credit-based read issue.
module mem_stream_reader #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 10,
  parameter int unsigned LW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clk_en,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          mem_rd,
  output logic [AW-1:0] mem_adr,
  input  logic [DW-1:0] mem_dat_r,
  output logic          out_vld,
  output logic [DW-1:0] out_dat,
  output logic          out_last,
  input  logic          out_rdy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] rem_q, rem_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          infl_q, infl_d;
  logic          infl_last_q, infl_last_d;
  logic          head_vld_q, head_vld_d;
  logic [DW-1:0] head_dat_q, head_dat_d;
  logic          head_last_q, head_last_d;
  logic          skid_vld_q, skid_vld_d;
  logic [DW-1:0] skid_dat_q, skid_dat_d;
  logic          skid_last_q, skid_last_d;

  logic          pop_c, push_c, issue_c;
  logic [2:0]    used_c;

  // Words buffered or in flight after this cycle's pop; a read is issued only while a slot stays free.
  always_comb begin
    pop_c   = clk_en && head_vld_q && out_rdy;
    push_c  = clk_en && infl_q;
    used_c  = 3'(head_vld_q) + 3'(skid_vld_q) + 3'(infl_q) - 3'(pop_c);
    issue_c = clk_en && (state_q == RUN) && (used_c < 3'd2);
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    busy_d      = busy_q;
    done_d      = done_q;
    infl_d      = infl_q;
    infl_last_d = infl_last_q;
    head_vld_d  = head_vld_q;
    head_dat_d  = head_dat_q;
    head_last_d = head_last_q;
    skid_vld_d  = skid_vld_q;
    skid_dat_d  = skid_dat_q;
    skid_last_d = skid_last_q;
    if (clk_en) begin
      done_d      = 1'b0;
      infl_d      = issue_c;
      infl_last_d = issue_c && (rem_q == LW'(1));
      if (issue_c) begin
        addr_d = addr_q + AW'(1);
        rem_d  = rem_q - LW'(1);
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              done_d = 1'b1;
            end else begin
              addr_d  = base;
              rem_d   = len;
              busy_d  = 1'b1;
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (issue_c && (rem_q == LW'(1))) state_d = DRAIN;
        end
        DRAIN: begin
          // The final word leaving the buffer means nothing else is buffered or in flight.
          if (pop_c && head_last_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      if (pop_c) begin
        if (skid_vld_q) begin
          head_dat_d  = skid_dat_q;
          head_last_d = skid_last_q;
          skid_vld_d  = 1'b0;
        end else begin
          head_vld_d  = 1'b0;
          head_last_d = 1'b0;
        end
      end
      if (push_c) begin
        if (!head_vld_d) begin
          head_vld_d  = 1'b1;
          head_dat_d  = mem_dat_r;
          head_last_d = infl_last_q;
        end else begin
          skid_vld_d  = 1'b1;
          skid_dat_d  = mem_dat_r;
          skid_last_d = infl_last_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      head_vld_q  <= 1'b0;
      head_dat_q  <= '0;
      head_last_q <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_dat_q  <= '0;
      skid_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      head_vld_q  <= head_vld_d;
      head_dat_q  <= head_dat_d;
      head_last_q <= head_last_d;
      skid_vld_q  <= skid_vld_d;
      skid_dat_q  <= skid_dat_d;
      skid_last_q <= skid_last_d;
    end
  end

  assign mem_rd   = issue_c;
  assign mem_adr  = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign out_vld  = head_vld_q;
  assign out_dat  = head_dat_q;
  assign out_last = head_last_q;

endmodule

// File: tb/tb_mem_stream_reader.sv
// Randomized self-checking bench for mem_stream_reader against a memory array
// and a transfer-level model of addresses, data order, last marker and done timing.
module tb_mem_stream_reader;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 10;
  localparam int unsigned LW = 11;
  localparam int unsigned MAX_EDGES = 400;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clk_en;
  logic          start;
  logic [AW-1:0] base;
  logic [LW-1:0] len;
  logic          busy, done, mem_rd, out_vld, out_last, out_rdy;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_dat_r, out_dat;

  logic [DW-1:0] mem [1024];
  int n_checks = 0;
  int n_errs   = 0;

  mem_stream_reader #(.DW(DW), .AW(AW), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .start(start), .base(base), .len(len),
    .busy(busy), .done(done), .mem_rd(mem_rd), .mem_adr(mem_adr), .mem_dat_r(mem_dat_r),
    .out_vld(out_vld), .out_dat(out_dat), .out_last(out_last), .out_rdy(out_rdy)
  );

  always #5 clk = ~clk;

  // Synchronous ROM with one-cycle read latency, gated by the shared clock enable.
  always @(posedge clk) if (clk_en && mem_rd) mem_dat_r <= mem[mem_adr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // mode 0: full rate with exact timing; 1: fixed backpressure pattern;
  // 2: random ready; 3: clk_en gap of 5 cycles, random ready and a stray start.
  task automatic run_xfer(input logic [AW-1:0] b, input int l, input int mode);
    int edge_n = 0, issued = 0, got = 0;
    bit done_seen = 0, exp_done = 0, hs;
    logic [5:0] pat = 6'b101001;
    @(negedge clk);
    start = 1'b1; base = b; len = LW'(l); clk_en = 1'b1; out_rdy = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (l == 0) begin
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk); #1;
        chk("zero_no_rd", mem_rd, 0);
        @(posedge clk); #1;
        chk("zero_done_once", done, 0);
        chk("zero_busy_low", busy, 0);
      end
      return;
    end
    chk("start_busy", busy, 1);
    while (!done_seen && edge_n < MAX_EDGES) begin
      @(negedge clk);
      case (mode)
        0: out_rdy = 1'b1;
        1: out_rdy = pat[edge_n % 6];
        default: out_rdy = 1'($urandom_range(0, 1));
      endcase
      clk_en = (mode == 3) ? !(edge_n >= 3 && edge_n < 8) : 1'b1;
      if (mode == 3 && edge_n == 10) begin
        start = 1'b1; base = '0; len = LW'(3);
      end
      #1;
      if (!clk_en) chk("gated_no_rd", mem_rd, 0);
      if (clk_en && mem_rd) begin
        chk("rd_in_range", issued < l, 1);
        chk("rd_addr", mem_adr, 32'(AW'(b + AW'(issued))));
        if (mode == 0) chk("rd_cycle", edge_n, issued);
        issued++;
      end
      hs = clk_en && out_vld && out_rdy;
      if (hs) begin
        chk("out_dat", out_dat, mem[AW'(b + AW'(got))]);
        chk("out_last", out_last, got == l - 1);
        if (mode == 0) chk("out_cycle", edge_n, got + 2);
        got++;
      end
      if (clk_en) exp_done = hs && (got == l);
      @(posedge clk);
      edge_n++;
      #1;
      start = 1'b0;
      chk("done", done, exp_done);
      chk("outstanding", (issued - got) <= 2, 1);
      if (done) begin
        done_seen = 1;
        chk("busy_with_done", busy, 0);
        if (mode == 0) chk("done_cycle", edge_n, l + 2);
      end
    end
    chk("xfer_finished", done_seen, 1);
    chk("issued_count", issued, l);
    chk("recv_count", got, l);
    @(negedge clk); clk_en = 1'b1;
    @(posedge clk); #1;
    chk("done_pulse_end", done, 0);
    chk("busy_end", busy, 0);
  endtask

  initial begin
    int hs_cnt;
    for (int i = 0; i < 1024; i++) mem[i] = DW'($urandom);
    mem[16] = 8'hA0; mem[17] = 8'hA1; mem[18] = 8'hA2; mem[19] = 8'hA3;
    rst_n = 1'b0; clk_en = 1'b0; start = 1'b0; base = '0; len = '0; out_rdy = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd", mem_rd, 0);
    chk("rst_vld", out_vld, 0);
    chk("rst_dat", out_dat, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    run_xfer(AW'(16), 4, 0);
    run_xfer(AW'(64), 6, 1);
    run_xfer(AW'(100), 0, 0);
    run_xfer(AW'(1022), 4, 0);
    run_xfer(AW'(200), 8, 3);
    for (int t = 0; t < 8; t++)
      run_xfer(AW'($urandom_range(0, 1023)), $urandom_range(1, 20), 2);
    run_xfer(AW'(1020), 12, 1);

    // Abort mid-transfer after the third accepted word.
    @(negedge clk);
    start = 1'b1; base = AW'(32); len = LW'(8); clk_en = 1'b1; out_rdy = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    hs_cnt = 0;
    for (int i = 0; i < 40 && hs_cnt < 3; i++) begin
      @(negedge clk); #1;
      if (out_vld && out_rdy) hs_cnt++;
      @(posedge clk); #1;
    end
    chk("abort_reached", hs_cnt, 3);
    @(negedge clk); rst_n = 1'b0; #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rd", mem_rd, 0);
    chk("abort_adr", mem_adr, 0);
    chk("abort_vld", out_vld, 0);
    chk("abort_dat", out_dat, 0);
    chk("abort_last", out_last, 0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort_no_done", done, 0);
    end
    @(negedge clk); rst_n = 1'b1;
    run_xfer(AW'(0), 2, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end
endmodule
